// File: rtl/tetris_key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_key_pkg
// Description : Shared command codes, key bit indices and counter width for
//               the push-button command decoder.
// Revision    : 1.0  initial release
// ============================================================================
package tetris_key_pkg;

  // Width of the debounce and auto-repeat counters
  localparam int CNT_W    = 16;
  localparam int NUM_KEYS = 5;

  // Bit positions inside key_state; a higher index means higher priority
  localparam int KEY_RIGHT = 0;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_UP    = 3;
  localparam int KEY_START = 4;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_START  = 3'd1,
    CMD_ROTATE = 3'd2,
    CMD_DROP   = 3'd3,
    CMD_LEFT   = 3'd4,
    CMD_RIGHT  = 3'd5
  } cmd_e;

  function automatic cmd_e key_to_cmd(input int idx);
    case (idx)
      KEY_START: return CMD_START;
      KEY_UP:    return CMD_ROTATE;
      KEY_DOWN:  return CMD_DROP;
      KEY_LEFT:  return CMD_LEFT;
      KEY_RIGHT: return CMD_RIGHT;
      default:   return CMD_NONE;
    endcase
  endfunction

  // Highest set index wins, which matches start > UP > DOWN > LEFT > RIGHT
  function automatic cmd_e pick_winner(input logic [NUM_KEYS-1:0] ev);
    cmd_e win;
    win = CMD_NONE;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (ev[i]) win = key_to_cmd(i);
    end
    return win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Two-flop synchronizer, counter debouncer and registered
//               rising-edge (press) detector for one raw push-button.
// Revision    : 1.0  initial release
// ============================================================================
module key_debounce
  import tetris_key_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic clr_n,
  input  logic raw,
  output logic level,
  output logic press
);

  logic             sync1;
  logic             sync2;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Flip the level only after DB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Registered one-cycle pulse on a debounced 0->1 transition
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/key_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : key_cmd_decoder
// Description : Debounces five push-buttons, auto-repeats LEFT/RIGHT/DOWN,
//               resolves same-cycle events by priority and queues the winner
//               in a 2-entry command FIFO with sticky overflow.
// Revision    : 1.0  initial release
// ============================================================================
module key_cmd_decoder
  import tetris_key_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = 4,
  parameter int unsigned REP_DELAY  = 16,
  parameter int unsigned REP_PERIOD = 8    // must not exceed REP_DELAY
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       UP,
  input  logic       LEFT,
  input  logic       RIGHT,
  input  logic       DOWN,
  input  logic       start,
  input  logic       cmd_ready,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  output logic [4:0] key_state,
  output logic       overflow
);

  logic [NUM_KEYS-1:0] raw_keys;
  logic [NUM_KEYS-1:0] levels;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] rep_evt;
  logic [NUM_KEYS-1:0] events;

  assign raw_keys[KEY_START] = start;
  assign raw_keys[KEY_UP]    = UP;
  assign raw_keys[KEY_DOWN]  = DOWN;
  assign raw_keys[KEY_LEFT]  = LEFT;
  assign raw_keys[KEY_RIGHT] = RIGHT;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .clr_n (clr_n),
      .raw   (raw_keys[i]),
      .level (levels[i]),
      .press (press[i])
    );
  end

  // Only the movement keys (indices RIGHT..DOWN) auto-repeat
  for (genvar i = 0; i <= KEY_DOWN; i++) begin : g_rep
    logic [CNT_W-1:0] rep_cnt;

    // rep_cnt counts cycles since the press pulse; zero means idle
    assign rep_evt[i] = levels[i] && (rep_cnt == CNT_W'(REP_DELAY));

    // Start on press, reload after each repeat, clear on release
    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        rep_cnt <= '0;
      end else if (!levels[i]) begin
        rep_cnt <= '0;
      end else if (press[i]) begin
        rep_cnt <= CNT_W'(1);
      end else if (rep_evt[i]) begin
        rep_cnt <= CNT_W'(REP_DELAY - REP_PERIOD + 1);
      end else if (rep_cnt != '0) begin
        rep_cnt <= rep_cnt + CNT_W'(1);
      end
    end
  end

  assign rep_evt[NUM_KEYS-1:KEY_DOWN+1] = '0;
  assign events = press | rep_evt;

  // Two-entry FIFO kept as head/tail registers so the head drives cmd directly
  logic head_v;
  logic tail_v;
  cmd_e head_c;
  cmd_e tail_c;
  logic head_v_nxt;
  logic tail_v_nxt;
  cmd_e head_c_nxt;
  cmd_e tail_c_nxt;
  cmd_e win_cmd;
  logic evt_any;
  logic full;
  logic pop;
  logic push;

  assign win_cmd = pick_winner(events);
  assign evt_any = |events;
  assign full    = head_v & tail_v;
  assign pop     = head_v & cmd_ready;
  assign push    = evt_any & (~full | pop);

  // Shift the queue on pop, then place the new winner in the first free slot
  always_comb begin
    head_v_nxt = head_v;
    head_c_nxt = head_c;
    tail_v_nxt = tail_v;
    tail_c_nxt = tail_c;
    if (pop) begin
      head_v_nxt = tail_v;
      head_c_nxt = tail_c;
      tail_v_nxt = 1'b0;
      tail_c_nxt = CMD_NONE;
    end
    if (push) begin
      if (!head_v_nxt) begin
        head_v_nxt = 1'b1;
        head_c_nxt = win_cmd;
      end else begin
        tail_v_nxt = 1'b1;
        tail_c_nxt = win_cmd;
      end
    end
  end

  // Queue storage; empty slots always hold CMD_NONE so cmd reads 0 when idle
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      head_v <= 1'b0;
      head_c <= CMD_NONE;
      tail_v <= 1'b0;
      tail_c <= CMD_NONE;
    end else begin
      head_v <= head_v_nxt;
      head_c <= head_c_nxt;
      tail_v <= tail_v_nxt;
      tail_c <= tail_c_nxt;
    end
  end

  // Sticky flag for a winner that found the queue full with no pop
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      overflow <= 1'b0;
    end else if (evt_any && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  assign cmd       = head_c;
  assign cmd_valid = head_v;
  assign key_state = levels;

endmodule
`default_nettype wire

// File: tb/tb_key_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_cmd_decoder
// Description : Directed bench for key_cmd_decoder with a cycle-level model of
//               debounce timing, repeat schedule, priority and the 2-deep queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_key_cmd_decoder;

  localparam int DB = 4;
  localparam int RD = 16;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic       UP = 1'b0, LEFT = 1'b0, RIGHT = 1'b0, DOWN = 1'b0, start = 1'b0;
  logic       cmd_ready = 1'b1;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [4:0] key_state;
  logic       overflow;

  int n_checks = 0;
  int n_pass   = 0;

  key_cmd_decoder #(
    .DB_CYCLES  (DB),
    .REP_DELAY  (RD),
    .REP_PERIOD (RP)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .UP        (UP),
    .LEFT      (LEFT),
    .RIGHT     (RIGHT),
    .DOWN      (DOWN),
    .start     (start),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .key_state (key_state),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // key index: 0 RIGHT, 1 LEFT, 2 DOWN, 3 UP, 4 start (priority grows with index)
  bit m_lvl[5];
  bit m_d1[5];
  bit m_d2[5];
  int m_run[5];
  int m_rise[5];
  int m_q[$];
  bit m_ovf;
  int m_edge;
  int code_of[5] = '{5, 4, 3, 2, 1};

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      m_lvl[k] = 0; m_d1[k] = 0; m_d2[k] = 0; m_run[k] = 0; m_rise[k] = -100000;
    end
    m_q.delete();
    m_ovf = 0;
  endtask

  task automatic model_step();
    bit raw_now[5];
    bit ev[5];
    bit any;
    int win;
    raw_now[0] = RIGHT; raw_now[1] = LEFT; raw_now[2] = DOWN;
    raw_now[3] = UP;    raw_now[4] = start;
    m_edge++;
    if (!clr_n) begin
      model_reset();
      return;
    end
    // a debounced rise at edge r is enqueued at r+2; repeats follow RD then every RP
    any = 0; win = 0;
    for (int k = 0; k < 5; k++) begin
      ev[k] = (m_edge == m_rise[k] + 2);
      if (k <= 2 && m_lvl[k] && m_edge >= m_rise[k] + 2 + RD &&
          ((m_edge - m_rise[k] - 2 - RD) % RP) == 0)
        ev[k] = 1;
      if (ev[k]) begin any = 1; win = k; end
    end
    // level follows the synchronized value after DB consecutive differing samples
    for (int k = 0; k < 5; k++) begin
      if (m_d2[k] != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == DB) begin
          m_lvl[k] = m_d2[k];
          m_run[k] = 0;
          if (m_lvl[k]) m_rise[k] = m_edge;
        end
      end else begin
        m_run[k] = 0;
      end
      m_d2[k] = m_d1[k];
      m_d1[k] = raw_now[k];
    end
    if (m_q.size() > 0 && cmd_ready) void'(m_q.pop_front());
    if (any) begin
      if (m_q.size() < 2) m_q.push_back(code_of[win]);
      else m_ovf = 1;
    end
  endtask

  function automatic logic [9:0] model_out();
    logic [4:0] ks;
    logic [2:0] c;
    for (int k = 0; k < 5; k++) ks[k] = m_lvl[k];
    c = (m_q.size() > 0) ? 3'(m_q[0]) : 3'd0;
    return {m_q.size() > 0, c, ks, m_ovf};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // one clock: advance model on the edge, compare outputs 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("cycle_outputs", int'({cmd_valid, cmd, key_state, overflow}), int'(model_out()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int vt[$];
  int n_up, n_start;
  int first_v;
  int exp_left[4] = '{7, 23, 31, 39};

  initial begin
    model_reset();
    m_edge = 0;

    // reset with every button high
    #1;
    {UP, LEFT, RIGHT, DOWN, start} = 5'b11111;
    clr_n = 1'b0;
    #1;
    check("reset_immediate", int'({cmd_valid, cmd, key_state, overflow}), 0);
    idle(5);
    check("reset_held", int'({cmd_valid, cmd, key_state, overflow}), 0);
    {UP, LEFT, RIGHT, DOWN, start} = 5'b00000;
    tick();
    clr_n = 1'b1;
    idle(10);

    // LEFT held 40 cycles: press then repeats, none after release
    vt.delete();
    for (int i = 0; i < 60; i++) begin
      LEFT = (i < 40);
      tick();
      if (cmd_valid) begin
        vt.push_back(i);
        check("left_code", int'(cmd), 4);
      end
    end
    check("left_count", vt.size(), 4);
    for (int j = 0; j < 4; j++)
      check("left_time", (j < vt.size()) ? vt[j] : -1, exp_left[j]);

    // UP glitch of 3 cycles is filtered
    vt.delete();
    n_up = 0;
    for (int i = 0; i < 20; i++) begin
      UP = (i < 3);
      tick();
      if (cmd_valid) vt.push_back(i);
      if (key_state[3]) n_up++;
    end
    check("glitch_cmds", vt.size(), 0);
    check("glitch_level", n_up, 0);

    // UP held 30 cycles gives one ROTATE
    vt.delete();
    for (int i = 0; i < 50; i++) begin
      UP = (i < 30);
      tick();
      if (cmd_valid) begin
        vt.push_back(i);
        check("up_code", int'(cmd), 2);
      end
    end
    check("up_count", vt.size(), 1);
    check("up_time", (vt.size() > 0) ? vt[0] : -1, 7);

    // start and UP together: only START
    vt.delete();
    n_up = 0; n_start = 0;
    for (int i = 0; i < 40; i++) begin
      start = (i < 20);
      UP    = (i < 20);
      tick();
      if (cmd_valid && cmd == 3'd2) n_up++;
      if (cmd_valid && cmd == 3'd1) n_start++;
    end
    check("prio_start", n_start, 1);
    check("prio_no_up", n_up, 0);
    check("prio_ovf", int'(overflow), 0);

    // stalled consumer: UP, DOWN queued, RIGHT dropped
    cmd_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin UP = (i < 10); tick(); end
    for (int i = 0; i < 16; i++) begin DOWN = (i < 10); tick(); end
    for (int i = 0; i < 20; i++) begin RIGHT = (i < 10); tick(); end
    check("full_head", int'({cmd_valid, cmd}), int'({1'b1, 3'd2}));
    check("full_ovf", int'(overflow), 1);
    cmd_ready = 1'b1;
    tick();
    check("drain_second", int'({cmd_valid, cmd}), int'({1'b1, 3'd3}));
    tick();
    check("drain_empty", int'({cmd_valid, cmd}), 0);
    check("drain_ovf_sticky", int'(overflow), 1);
    idle(3);

    // reset while DOWN held and a command pending
    cmd_ready = 1'b0;
    DOWN = 1'b1;
    idle(10);
    check("pend_before_reset", int'({cmd_valid, cmd}), int'({1'b1, 3'd3}));
    #1;
    clr_n = 1'b0;
    #1;
    check("reset_clears", int'({cmd_valid, cmd, key_state, overflow}), 0);
    idle(2);
    clr_n = 1'b1;
    cmd_ready = 1'b1;
    first_v = -1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (cmd_valid && first_v < 0) begin
        first_v = i;
        check("rerelease_code", int'(cmd), 3);
      end
    end
    check("rerelease_time", first_v, 7);
    DOWN = 1'b0;
    idle(15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_cmd_decoder.md
KEY_CMD_DECODER -- requirements
Module: key_cmd_decoder

Interface
REQ-001 Parameter DB_CYCLES, default 4, consecutive stable synchronized samples needed to change a debounced level.
REQ-002 Parameter REP_DELAY, default 16, cycles from press event to first auto-repeat event.
REQ-003 Parameter REP_PERIOD, default 8, cycles between subsequent auto-repeat events.
REQ-004 clk  in  1  single system clock, all logic on rising edge.
REQ-005 clr_n  in  1  reset, asynchronous assert, active-low.
REQ-006 UP, LEFT, RIGHT, DOWN, start  in  1 each  raw asynchronous push-buttons, active-high.
REQ-007 cmd  out  3  command code: 0 NONE, 1 START, 2 ROTATE (UP), 3 DROP (DOWN), 4 LEFT, 5 RIGHT.
REQ-008 cmd_valid  out  1  cmd holds a valid command.
REQ-009 cmd_ready  in  1  consumer (game FSM) accepts cmd this cycle.
REQ-010 key_state  out  5  debounced levels {start, UP, DOWN, LEFT, RIGHT}, MSB first.
REQ-011 overflow  out  1  sticky: an event was dropped because the queue was full.

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer before any other logic.
REQ-013 Per key, debounce counter SHALL increment while synchronized level differs from debounced level, clear when equal; debounced level SHALL toggle and counter clear when counter reaches DB_CYCLES-1 with difference still present.
REQ-014 Press event SHALL be a debounced 0->1 transition, one cycle wide.
REQ-015 LEFT, RIGHT, DOWN SHALL auto-repeat: while debounced level high, repeat events at REP_DELAY cycles after press event, then every REP_PERIOD cycles; repeat counter SHALL clear on debounced release.
REQ-016 UP and start SHALL never auto-repeat; holding produces exactly one event.
REQ-017 Same-cycle events SHALL be resolved by priority start > UP > DOWN > LEFT > RIGHT; only the winner is enqueued, losers discarded without setting overflow.
REQ-018 Winning events SHALL enter a 2-entry FIFO; cmd/cmd_valid SHALL reflect its head from registers.
REQ-019 Pop SHALL occur on cmd_valid && cmd_ready; cmd SHALL stay stable while cmd_valid && !cmd_ready.
REQ-020 Push when full SHALL be accepted only if a pop occurs the same cycle; otherwise the event is dropped and overflow set.
REQ-021 overflow SHALL clear only on reset.
REQ-022 With empty FIFO and stable raw input, cmd_valid SHALL assert DB_CYCLES+3 rising edges after the first edge sampling raw high.
REQ-023 cmd SHALL be 0 (NONE) whenever cmd_valid is 0.

Reset
REQ-024 clr_n low SHALL immediately clear synchronizers, debounced levels, all counters, FIFO pointers, overflow; cmd_valid=0, cmd=0, key_state=0.
REQ-025 A button held across reset release SHALL be re-debounced and produce a fresh press event.

Structure
REQ-026 Command codes, key bit indices, counter width (16 bits) SHALL live in shared package tetris_key_pkg.
REQ-027 Synchronizer+debouncer+edge detect SHALL be one sub-module key_debounce, instantiated five times; repeat, priority and FIFO in the top module.

Verification (DB_CYCLES=4, REP_DELAY=16, REP_PERIOD=8, cmd_ready=1 unless stated)
REQ-028 clr_n=0 with all buttons high -> cmd_valid=0, cmd=0, key_state=0, overflow=0 throughout reset.
REQ-029 LEFT raised at cycle 0, held 40 cycles -> cmd=4 valid at cycle 7, repeats at 23, 31, 39, then further repeats until debounced release, none afterwards.
REQ-030 UP glitch high for 3 cycles -> no command, key_state[3] stays 0; UP held 30 cycles -> exactly one cmd=2.
REQ-031 start and UP raised same cycle -> single cmd=1, no cmd=2, overflow=0.
REQ-032 cmd_ready=0; press UP, then DOWN, then RIGHT -> FIFO holds 2, 3; RIGHT dropped, overflow=1; cmd_ready=1 -> cmd 2 then 3, cmd_valid falls, overflow remains 1.
REQ-033 clr_n pulsed low while DOWN held and a command pending -> queue cleared; after release, new cmd=3 at cycle 7 after reset deassertion.
